ccu_snoop_arbiter: RTL and testbench
====================================

CCU_SNOOP_ARBITER -- requirements
Module: ccu_snoop_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, giving the number of snoop requesters (read-snoop and write-snoop controllers).
REQ-002 SHALL have parameter OrderDepth, default 4, giving the maximum number of outstanding AC requests tracked.
REQ-003 SHALL have parameters snoop_req_t and snoop_resp_t, default logic, giving the snoop request/response struct types (ac, cr_resp, cd fields as in ace_pkg).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port slv_snoop_req_i, input, snoop_req_t[NumReq]: AC valid/payload, cr_ready and cd_ready from each requester.
REQ-007 SHALL have port slv_snoop_resp_o, output, snoop_resp_t[NumReq]: ac_ready, CR and CD toward each requester.
REQ-008 SHALL have port mst_snoop_req_o, output, snoop_req_t: merged request toward the snoop crossbar.
REQ-009 SHALL have port mst_snoop_resp_i, input, snoop_resp_t: ac_ready, CR and CD from the snoop crossbar.

Function
REQ-010 SHALL arbitrate AC round-robin among requesters asserting ac_valid; the priority pointer advances to grant+1 (mod NumReq) only on an AC handshake.
REQ-011 SHALL lock the grant while mst ac_valid is high and ac_ready is low, keeping payload and valid stable until the handshake.
REQ-012 SHALL assert mst ac_valid only when the CR-order FIFO is not full; a full FIFO blocks all AC (ac_ready=0 to every requester).
REQ-013 SHALL return ac_ready only to the granted requester, equal to mst ac_ready AND CR-order FIFO not full.
REQ-014 SHALL push the granted index into the CR-order FIFO on each AC handshake.
REQ-015 SHALL forward CR only to the CR-order FIFO head; mst cr_ready equals that requester's cr_ready; with the FIFO empty, cr_ready=0 and all requester cr_valid=0.
REQ-016 SHALL pop the CR-order FIFO on a CR handshake and, if cr_resp.DataTransfer=1, push the same index into the CD-order FIFO (depth OrderDepth).
REQ-017 SHALL deassert mst cr_ready while the CD-order FIFO is full and the head CR has DataTransfer=1.
REQ-018 SHALL forward CD beats only to the CD-order FIFO head; mst cd_ready equals that requester's cd_ready; with the FIFO empty, cd_ready=0.
REQ-019 SHALL pop the CD-order FIFO on a CD handshake with cd.last=1.
REQ-020 SHALL not bypass: an index pushed in cycle t is visible at a FIFO head no earlier than t+1; a simultaneous push and pop on a non-empty FIFO SHALL keep its occupancy unchanged.
REQ-021 SHALL hold all non-selected requester outputs at valid=0 and payload '0.

Reset
REQ-022 SHALL, on rst_ni=0 at a clock edge, empty both FIFOs, set the RR pointer to 0, and release the grant lock.
REQ-023 SHALL drive all valid and ready outputs to 0 during reset; a mid-burst reset SHALL discard outstanding order state without emitting further beats.

Structure
REQ-024 SHALL use an index type sized $clog2(NumReq) for requester indices, declared locally; no new ace_pkg entries are needed.
REQ-025 SHALL instantiate stream_fifo twice (CR order, CD order) as its only sub-module; arbitration is in-module RTL.

Verification
REQ-026 SHALL be verified by: req0 and req1 both assert AC in the same cycle with ac_ready=1 -> grant 0 then 1 on consecutive cycles, and CR routed to 0 then 1.
REQ-027 SHALL be verified by: crossbar holds ac_ready=0 for 3 cycles while req1 raises valid -> req0 payload is stable and the grant does not switch.
REQ-028 SHALL be verified by: 4 ACs accepted with no CR -> 5th AC blocked (ac_ready=0) until one CR handshake occurs.
REQ-029 SHALL be verified by: CR to req1 with DataTransfer=1, then a 4-beat CD -> all 4 beats go only to req1, and the CD-order FIFO pops on beat 4.
REQ-030 SHALL be verified by: CR with DataTransfer=0 -> no CD-order push, and mst cd_ready stays 0.
REQ-031 SHALL be verified by: rst_ni=0 asserted after CD beat 2 -> next cycle both FIFOs are empty and all valids are 0.

Source files
------------

// File: rtl/ccu_snoop_arbiter_pkg.sv
// Types shared by the snoop arbiter and its bench: AC/CR/CD channel payloads and the
// requester-side snoop request/response bundles (field layout follows ace_pkg).
package ccu_snoop_arbiter_pkg;

  localparam int unsigned AddrWidth = 16;
  localparam int unsigned DataWidth = 32;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
  } ac_chan_t;

  // Bit order matches CRRESP[4:0].
  typedef struct packed {
    logic WasUnique;
    logic IsShared;
    logic PassDirty;
    logic Error;
    logic DataTransfer;
  } cr_resp_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } ccu_snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_resp_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } ccu_snoop_resp_t;

endpackage

// File: rtl/stream_fifo.sv
// Small valid/ready FIFO used to remember requester order for CR and CD routing.
// No fall-through: a pushed entry appears at data_o one cycle later at the earliest.
// Ports: clk_i, rst_ni (sync, active-low), data_i/valid_i/ready_o (push side),
//        data_o/valid_o/ready_i (pop side).
module stream_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output T     data_o,
  output logic valid_o,
  input  logic ready_i
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  T     mem_q [Depth];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t cnt_q, cnt_d;
  logic push, pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (32'(p) == Depth - 1) ? '0 : p + ptr_t'(1);
  endfunction

  assign ready_o = (32'(cnt_q) != Depth);
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ccu_snoop_arbiter.sv
// Merges NumReq snoop requesters onto one snoop crossbar port.
// AC is arbitrated round-robin and locked until handshake; CR and CD are routed back in
// AC order via two order FIFOs (CR order, then CD order for responses carrying data).
// Ports: clk_i, rst_ni (sync, active-low), slv_snoop_req_i/slv_snoop_resp_o (per
//        requester), mst_snoop_req_o/mst_snoop_resp_i (toward the crossbar).
module ccu_snoop_arbiter import ccu_snoop_arbiter_pkg::*; #(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned OrderDepth   = 4,
  parameter type         snoop_req_t  = ccu_snoop_req_t,
  parameter type         snoop_resp_t = ccu_snoop_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  snoop_req_t  slv_snoop_req_i  [NumReq],
  output snoop_resp_t slv_snoop_resp_o [NumReq],
  output snoop_req_t  mst_snoop_req_o,
  input  snoop_resp_t mst_snoop_resp_i
);

  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef logic [IdxWidth-1:0] idx_t;

  idx_t rr_q, rr_d;
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;

  idx_t gnt_idx;
  logic gnt_valid;

  logic cr_fifo_ready, cr_fifo_valid;
  logic cd_fifo_ready, cd_fifo_valid;
  idx_t cr_head, cd_head;

  logic mst_ac_valid, mst_cr_ready, mst_cd_ready;
  logic ac_hs, cr_hs, cr_dt, cr_block, cd_push, cd_pop;

  // Round-robin search starting at rr_q; a locked grant overrides the search.
  always_comb begin
    gnt_idx   = lock_idx_q;
    gnt_valid = 1'b0;
    if (lock_q) begin
      gnt_valid = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (!gnt_valid && slv_snoop_req_i[(32'(rr_q) + i) % NumReq].ac_valid) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx_t'((32'(rr_q) + i) % NumReq);
        end
      end
    end
  end

  assign mst_ac_valid = rst_ni & gnt_valid & cr_fifo_ready;
  assign ac_hs        = mst_ac_valid & mst_snoop_resp_i.ac_ready;

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (ac_hs) begin
      lock_d = 1'b0;
      rr_d   = (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + idx_t'(1);
    end else if (mst_ac_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
  end

  // A data-carrying CR must not complete unless the CD order FIFO can take its index.
  assign cr_dt        = mst_snoop_resp_i.cr_resp.DataTransfer;
  assign cr_block     = cr_dt & ~cd_fifo_ready;
  assign mst_cr_ready = rst_ni & cr_fifo_valid & ~cr_block & slv_snoop_req_i[cr_head].cr_ready;
  assign cr_hs        = mst_snoop_resp_i.cr_valid & mst_cr_ready;
  assign cd_push      = cr_hs & cr_dt;

  assign mst_cd_ready = rst_ni & cd_fifo_valid & slv_snoop_req_i[cd_head].cd_ready;
  assign cd_pop       = mst_snoop_resp_i.cd_valid & mst_cd_ready & mst_snoop_resp_i.cd.last;

  always_comb begin
    mst_snoop_req_o          = '0;
    mst_snoop_req_o.ac_valid = mst_ac_valid;
    mst_snoop_req_o.cr_ready = mst_cr_ready;
    mst_snoop_req_o.cd_ready = mst_cd_ready;
    if (mst_ac_valid) begin
      mst_snoop_req_o.ac = slv_snoop_req_i[gnt_idx].ac;
    end

    for (int unsigned i = 0; i < NumReq; i++) begin
      slv_snoop_resp_o[i] = '0;
    end
    if (mst_ac_valid) begin
      slv_snoop_resp_o[gnt_idx].ac_ready = mst_snoop_resp_i.ac_ready;
    end
    // CR valid is withheld while blocked so the requester never sees a one-sided handshake.
    if (rst_ni && cr_fifo_valid) begin
      slv_snoop_resp_o[cr_head].cr_valid = mst_snoop_resp_i.cr_valid & ~cr_block;
      slv_snoop_resp_o[cr_head].cr_resp  = mst_snoop_resp_i.cr_resp;
    end
    if (rst_ni && cd_fifo_valid) begin
      slv_snoop_resp_o[cd_head].cd_valid = mst_snoop_resp_i.cd_valid;
      slv_snoop_resp_o[cd_head].cd       = mst_snoop_resp_i.cd;
    end
  end

  stream_fifo #(
    .Depth (OrderDepth),
    .T     (idx_t)
  ) u_cr_order (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (gnt_idx),
    .valid_i (ac_hs),
    .ready_o (cr_fifo_ready),
    .data_o  (cr_head),
    .valid_o (cr_fifo_valid),
    .ready_i (cr_hs)
  );

  stream_fifo #(
    .Depth (OrderDepth),
    .T     (idx_t)
  ) u_cd_order (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (cr_head),
    .valid_i (cd_push),
    .ready_o (cd_fifo_ready),
    .data_o  (cd_head),
    .valid_o (cd_fifo_valid),
    .ready_i (cd_pop)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Directed bench for ccu_snoop_arbiter with two requesters and order depth 4.
module tb_ccu_snoop_arbiter;
  import ccu_snoop_arbiter_pkg::*;

  localparam int unsigned NumReq = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  ccu_snoop_req_t  slv_req  [NumReq];
  ccu_snoop_resp_t slv_resp [NumReq];
  ccu_snoop_req_t  mst_req;
  ccu_snoop_resp_t mst_resp;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  ccu_snoop_arbiter #(
    .NumReq       (NumReq),
    .OrderDepth   (4),
    .snoop_req_t  (ccu_snoop_req_t),
    .snoop_resp_t (ccu_snoop_resp_t)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .slv_snoop_req_i  (slv_req),
    .slv_snoop_resp_o (slv_resp),
    .mst_snoop_req_o  (mst_req),
    .mst_snoop_resp_i (mst_resp)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int unsigned exp_head [3] = '{0, 0, 1};

  initial begin
    for (int i = 0; i < int'(NumReq); i++) slv_req[i] = '0;
    mst_resp = '0;
    rst_ni   = 1'b0;

    // Activity on inputs during reset must not leak to outputs.
    slv_req[0].ac_valid = 1'b1;
    slv_req[0].ac.addr  = 16'h1111;
    slv_req[0].cr_ready = 1'b1;
    slv_req[0].cd_ready = 1'b1;
    mst_resp.ac_ready   = 1'b1;
    mst_resp.cr_valid   = 1'b1;
    mst_resp.cd_valid   = 1'b1;
    tick();
    tick();
    check_eq("rst_mst_ac_valid", 64'(mst_req.ac_valid), 64'h0);
    check_eq("rst_slv0_ac_ready", 64'(slv_resp[0].ac_ready), 64'h0);
    check_eq("rst_mst_cr_ready", 64'(mst_req.cr_ready), 64'h0);
    check_eq("rst_mst_cd_ready", 64'(mst_req.cd_ready), 64'h0);
    for (int i = 0; i < int'(NumReq); i++) slv_req[i] = '0;
    mst_resp = '0;
    rst_ni   = 1'b1;

    // Simultaneous AC from both requesters: grant 0 then 1, CR routed 0 then 1.
    for (int i = 0; i < int'(NumReq); i++) begin
      slv_req[i].cr_ready = 1'b1;
      slv_req[i].cd_ready = 1'b1;
    end
    slv_req[0].ac_valid = 1'b1;
    slv_req[0].ac.addr  = 16'h00A0;
    slv_req[1].ac_valid = 1'b1;
    slv_req[1].ac.addr  = 16'h00B1;
    mst_resp.ac_ready   = 1'b1;
    settle();
    check_eq("rr_first_addr", 64'(mst_req.ac.addr), 64'h00A0);
    check_eq("rr_first_ready0", 64'(slv_resp[0].ac_ready), 64'h1);
    check_eq("rr_first_ready1", 64'(slv_resp[1].ac_ready), 64'h0);
    mst_resp.cr_valid = 1'b1;
    settle();
    check_eq("cr_empty_ready", 64'(mst_req.cr_ready), 64'h0);
    check_eq("cr_empty_valid0", 64'(slv_resp[0].cr_valid), 64'h0);
    mst_resp.cr_valid = 1'b0;
    tick();
    slv_req[0].ac_valid = 1'b0;
    settle();
    check_eq("rr_second_addr", 64'(mst_req.ac.addr), 64'h00B1);
    check_eq("rr_second_ready1", 64'(slv_resp[1].ac_ready), 64'h1);
    tick();
    slv_req[1].ac_valid = 1'b0;
    mst_resp.cr_valid   = 1'b1;
    mst_resp.cr_resp    = '0;
    mst_resp.cd_valid   = 1'b1;
    settle();
    check_eq("cr0_valid0", 64'(slv_resp[0].cr_valid), 64'h1);
    check_eq("cr0_valid1", 64'(slv_resp[1].cr_valid), 64'h0);
    check_eq("cr0_mst_ready", 64'(mst_req.cr_ready), 64'h1);
    check_eq("cd_empty_ready", 64'(mst_req.cd_ready), 64'h0);
    tick();
    settle();
    check_eq("cr1_valid1", 64'(slv_resp[1].cr_valid), 64'h1);
    check_eq("cr1_valid0", 64'(slv_resp[0].cr_valid), 64'h0);
    tick();
    settle();
    check_eq("nodt_cd_ready", 64'(mst_req.cd_ready), 64'h0);
    check_eq("nodt_cd_valid1", 64'(slv_resp[1].cd_valid), 64'h0);
    check_eq("cr_drained_ready", 64'(mst_req.cr_ready), 64'h0);
    mst_resp.cr_valid = 1'b0;
    mst_resp.cd_valid = 1'b0;

    // Grant lock: move pointer to 1, then stall req0 while req1 competes.
    slv_req[0].ac_valid = 1'b1;
    slv_req[0].ac.addr  = 16'h00C0;
    mst_resp.ac_ready   = 1'b1;
    tick();
    slv_req[0].ac.addr = 16'h00C2;
    mst_resp.ac_ready  = 1'b0;
    settle();
    check_eq("lock_first_addr", 64'(mst_req.ac.addr), 64'h00C2);
    tick();
    slv_req[1].ac_valid = 1'b1;
    slv_req[1].ac.addr  = 16'h00D1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("lock_hold_addr", 64'(mst_req.ac.addr), 64'h00C2);
      check_eq("lock_hold_valid", 64'(mst_req.ac_valid), 64'h1);
      tick();
    end
    mst_resp.ac_ready = 1'b1;
    settle();
    check_eq("lock_rel_ready0", 64'(slv_resp[0].ac_ready), 64'h1);
    check_eq("lock_rel_ready1", 64'(slv_resp[1].ac_ready), 64'h0);
    tick();
    slv_req[0].ac_valid = 1'b0;
    settle();
    check_eq("after_lock_addr", 64'(mst_req.ac.addr), 64'h00D1);
    tick();
    slv_req[1].ac_valid = 1'b0;
    mst_resp.cr_valid   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("drain_head", 64'(slv_resp[exp_head[k]].cr_valid), 64'h1);
      tick();
    end
    mst_resp.cr_valid = 1'b0;

    // Full CR order FIFO blocks the fifth AC until one CR completes.
    slv_req[0].ac_valid = 1'b1;
    slv_req[0].ac.addr  = 16'h00E0;
    for (int k = 0; k < 4; k++) tick();
    settle();
    check_eq("full_mst_ac_valid", 64'(mst_req.ac_valid), 64'h0);
    check_eq("full_ready0", 64'(slv_resp[0].ac_ready), 64'h0);
    tick();
    check_eq("full_hold_ready0", 64'(slv_resp[0].ac_ready), 64'h0);
    mst_resp.cr_valid = 1'b1;
    settle();
    check_eq("full_same_cycle_ready0", 64'(slv_resp[0].ac_ready), 64'h0);
    tick();
    mst_resp.cr_valid = 1'b0;
    settle();
    check_eq("unblock_ready0", 64'(slv_resp[0].ac_ready), 64'h1);
    check_eq("unblock_mst_valid", 64'(mst_req.ac_valid), 64'h1);
    tick();
    slv_req[0].ac_valid = 1'b0;
    mst_resp.cr_valid   = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    mst_resp.cr_valid = 1'b0;
    settle();
    check_eq("full_drained_ready", 64'(mst_req.cr_ready), 64'h0);

    // Data-carrying CR to req1 followed by a 4-beat CD burst.
    slv_req[1].ac_valid = 1'b1;
    slv_req[1].ac.addr  = 16'h00F1;
    tick();
    slv_req[1].ac_valid           = 1'b0;
    mst_resp.cr_valid             = 1'b1;
    mst_resp.cr_resp.DataTransfer = 1'b1;
    mst_resp.cd_valid             = 1'b1;
    mst_resp.cd.data              = 32'hBEEF_0000;
    mst_resp.cd.last              = 1'b0;
    settle();
    check_eq("dt_cr_valid1", 64'(slv_resp[1].cr_valid), 64'h1);
    check_eq("dt_cr_valid0", 64'(slv_resp[0].cr_valid), 64'h0);
    check_eq("dt_mst_cr_ready", 64'(mst_req.cr_ready), 64'h1);
    check_eq("dt_cd_no_bypass", 64'(mst_req.cd_ready), 64'h0);
    tick();
    mst_resp.cr_valid = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      mst_resp.cd.data = 32'hBEEF_0000 + 32'(b);
      mst_resp.cd.last = (b == 4);
      settle();
      check_eq("cd_valid1", 64'(slv_resp[1].cd_valid), 64'h1);
      check_eq("cd_data1", 64'(slv_resp[1].cd.data), 64'hBEEF_0000 + 64'(b));
      check_eq("cd_valid0", 64'(slv_resp[0].cd_valid), 64'h0);
      check_eq("cd_data0", 64'(slv_resp[0].cd.data), 64'h0);
      check_eq("cd_mst_ready", 64'(mst_req.cd_ready), 64'h1);
      tick();
    end
    settle();
    check_eq("cd_popped_ready", 64'(mst_req.cd_ready), 64'h0);
    check_eq("cd_popped_valid1", 64'(slv_resp[1].cd_valid), 64'h0);
    mst_resp.cd_valid = 1'b0;
    mst_resp.cd.last  = 1'b0;

    // Reset in the middle of a CD burst with another CR still outstanding.
    slv_req[1].ac_valid = 1'b1;
    slv_req[1].ac.addr  = 16'h00A1;
    tick();
    slv_req[1].ac.addr = 16'h00A3;
    tick();
    slv_req[1].ac_valid = 1'b0;
    mst_resp.cr_valid   = 1'b1;
    tick();
    mst_resp.cr_valid = 1'b0;
    mst_resp.cd_valid = 1'b1;
    tick();
    tick();
    rst_ni            = 1'b0;
    mst_resp.cr_valid = 1'b1;
    settle();
    check_eq("midrst_cd_valid1", 64'(slv_resp[1].cd_valid), 64'h0);
    check_eq("midrst_cd_ready", 64'(mst_req.cd_ready), 64'h0);
    tick();
    rst_ni = 1'b1;
    settle();
    check_eq("postrst_cd_valid1", 64'(slv_resp[1].cd_valid), 64'h0);
    check_eq("postrst_cd_ready", 64'(mst_req.cd_ready), 64'h0);
    check_eq("postrst_cr_valid1", 64'(slv_resp[1].cr_valid), 64'h0);
    check_eq("postrst_cr_ready", 64'(mst_req.cr_ready), 64'h0);
    check_eq("postrst_ac_valid", 64'(mst_req.ac_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
